// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter in front of the single-port ssdram controller: video, CPU and loader.
// Each access holds cs for a fixed number of cycles, then acks the owner and leaves a one-cycle gap.
module sdram_port_arbiter #(
    parameter int ADDR_W        = 24,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 8,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic              vid_ack_o,
    output logic [DATA_W-1:0] vid_data_o,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_data_o,
    input  logic              ldr_req_i,
    input  logic [ADDR_W-1:0] ldr_addr_i,
    input  logic [DATA_W-1:0] ldr_data_i,
    output logic              ldr_ack_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              ram_cs_o,
    output logic              ram_oe_o,
    output logic              ram_we_o,
    output logic [1:0]        grant_o
);

    localparam logic [7:0] CNT_INIT  = 8'(ACCESS_CYCLES - 1);
    localparam logic [7:0] STARVE_TH = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_GAP
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [7:0]        starve_reg, starve_next;
    logic [1:0]        owner_reg, owner_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] vid_data_reg, vid_data_next;
    logic [DATA_W-1:0] cpu_data_reg, cpu_data_next;
    logic [1:0]        win_sel;
    logic [2:0]        ack_vec;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            starve_reg   <= '0;
            owner_reg    <= '0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            vid_data_reg <= '0;
            cpu_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            starve_reg   <= starve_next;
            owner_reg    <= owner_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            vid_data_reg <= vid_data_next;
            cpu_data_reg <= cpu_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        starve_next   = starve_reg;
        owner_next    = owner_reg;
        we_next       = we_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        vid_data_next = vid_data_reg;
        cpu_data_next = cpu_data_reg;
        win_sel       = 2'd0;

        case (state_reg)
            ST_IDLE: begin
                // A starved loader overrides the fixed video > CPU > loader order
                if (ldr_req_i && (starve_reg >= STARVE_TH)) win_sel = 2'd3;
                else if (vid_req_i)                         win_sel = 2'd1;
                else if (cpu_req_i)                         win_sel = 2'd2;
                else if (ldr_req_i)                         win_sel = 2'd3;

                case (win_sel)
                    2'd1: begin
                        addr_next  = vid_addr_i;
                        wdata_next = '0;
                        we_next    = 1'b0;
                    end
                    2'd2: begin
                        addr_next  = cpu_addr_i;
                        wdata_next = cpu_data_i;
                        we_next    = cpu_we_i;
                    end
                    2'd3: begin
                        addr_next  = ldr_addr_i;
                        wdata_next = ldr_data_i;
                        we_next    = 1'b1;
                    end
                    default: ;
                endcase

                if (win_sel != 2'd0) begin
                    owner_next = win_sel;
                    cnt_next   = CNT_INIT;
                    state_next = ST_ACCESS;
                end

                if (!ldr_req_i || (win_sel == 2'd3)) starve_next = 8'd0;
                else if (starve_reg != 8'hFF)        starve_next = starve_reg + 8'd1;
            end
            ST_ACCESS: begin
                if (cnt_reg == 8'd0) begin
                    state_next = ST_DONE;
                    // ram_data_i is valid on the last access cycle only
                    if (!we_reg) begin
                        if (owner_reg == 2'd1)      vid_data_next = ram_data_i;
                        else if (owner_reg == 2'd2) cpu_data_next = ram_data_i;
                    end
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                end
            end
            ST_DONE: begin
                owner_next = 2'd0;
                state_next = ST_GAP;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_ack
        assign ack_vec[gi] = (state_reg == ST_DONE) && (owner_reg == 2'(gi + 1));
    end

    assign vid_ack_o  = ack_vec[0];
    assign cpu_ack_o  = ack_vec[1];
    assign ldr_ack_o  = ack_vec[2];
    assign vid_data_o = vid_data_reg;
    assign cpu_data_o = cpu_data_reg;
    assign ram_addr_o = addr_reg;
    assign ram_data_o = wdata_reg;
    assign ram_cs_o   = (state_reg == ST_ACCESS);
    assign ram_oe_o   = (state_reg == ST_ACCESS) && !we_reg;
    assign ram_we_o   = (state_reg == ST_ACCESS) && we_reg;
    assign grant_o    = owner_reg;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small ssdram model and an ack scoreboard.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_req, cpu_req, cpu_we, ldr_req;
    logic [23:0] vid_addr, cpu_addr, ldr_addr;
    logic [7:0]  cpu_wdata, ldr_data;
    logic        vid_ack, cpu_ack, ldr_ack;
    logic [7:0]  vid_data, cpu_rdata;
    logic [23:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_cs, ram_oe, ram_we;
    logic [1:0]  grant;

    typedef struct packed {
        logic [1:0] who;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   cs_len = 0;
    int   last_cs_len = 0;
    int   cs_cycles = 0;
    int   we_cycles = 0;
    int   ack_total = 0;
    int   last_who = 0;
    int   lat = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W(24), .DATA_W(8), .ACCESS_CYCLES(8), .STARVE_LIMIT(4)
    ) dut (
        .clock_i(clk), .reset_i(rst),
        .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_ack_o(vid_ack), .vid_data_o(vid_data),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
        .cpu_ack_o(cpu_ack), .cpu_data_o(cpu_rdata),
        .ldr_req_i(ldr_req), .ldr_addr_i(ldr_addr), .ldr_data_i(ldr_data), .ldr_ack_o(ldr_ack),
        .ram_addr_o(ram_addr), .ram_data_o(ram_wdata), .ram_data_i(ram_rdata),
        .ram_cs_o(ram_cs), .ram_oe_o(ram_oe), .ram_we_o(ram_we), .grant_o(grant)
    );

    // ssdram stand-in: asynchronous read, write on clock while cs & we
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (rst) begin
            mem[16'h0123] <= 8'h5A;
            mem[16'h0200] <= 8'h3C;
        end else if (ram_cs && ram_we) begin
            mem[ram_addr[15:0]] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr[15:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge, track strobes and score any ack
    task automatic tick();
        exp_t e;
        int   who;
        @(negedge clk);
        cyc++;
        if (ram_cs) begin
            cs_len++;
            cs_cycles++;
        end else if (cs_len != 0) begin
            last_cs_len = cs_len;
            cs_len = 0;
        end
        if (ram_we) we_cycles++;
        who = vid_ack ? 1 : (cpu_ack ? 2 : (ldr_ack ? 3 : 0));
        last_who = who;
        if (who != 0) begin
            ack_total++;
            check("ack_onehot", 32'($countones({vid_ack, cpu_ack, ldr_ack})), 32'd1);
            check("ack_in_done", 32'({ram_cs, grant}), 32'(who));
            if (sb.size() == 0) begin
                check("sb_unexpected_ack", 32'(who), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_owner", 32'(who), 32'(e.who));
                if (who == 1) check("sb_vid_data", 32'(vid_data), 32'(e.data));
                if (who == 2) check("sb_cpu_data", 32'(cpu_rdata), 32'(e.data));
                $display("txn cyc=%0d who=%0d rd=%0d vid_data=%02h cpu_data=%02h", cyc, who, e.rd,
                         vid_data, cpu_rdata);
            end
        end
    endtask

    task automatic wait_ack(input int which, output int n);
        n = 0;
        forever begin
            tick();
            n++;
            if (last_who == which) break;
            if (n > 60) begin
                check("ack_timeout", 32'(last_who), 32'(which));
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; ldr_req = 1'b0;
        vid_addr = '0; cpu_addr = '0; ldr_addr = '0; cpu_wdata = '0; ldr_data = '0;
        repeat (3) tick();

        // Reset state
        check("rst_strobes", 32'({ram_cs, ram_oe, ram_we}), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_acks", 32'({vid_ack, cpu_ack, ldr_ack}), 32'd0);
        check("rst_data", 32'({vid_data, cpu_rdata}), 32'd0);
        rst = 1'b0;
        tick();

        // CPU read of 0x000123
        cpu_addr = 24'h000123; cpu_we = 1'b0; cpu_req = 1'b1;
        sb.push_back('{who: 2'd2, rd: 1'b1, data: 8'h5A});
        tick();
        check("cpu_rd_grant", 32'(grant), 32'd2);
        check("cpu_rd_oe", 32'({ram_cs, ram_oe, ram_we}), 32'b110);
        wait_ack(2, lat);
        cpu_req = 1'b0;
        check("cpu_rd_latency", 32'(lat + 1), 32'd9);
        check("cpu_rd_cs_len", 32'(last_cs_len), 32'd8);
        repeat (3) tick();
        check("cpu_rd_hold", 32'(cpu_rdata), 32'h5A);

        // Video and CPU in the same cycle
        vid_addr = 24'h000123; vid_req = 1'b1;
        cpu_addr = 24'h000200; cpu_we = 1'b0; cpu_req = 1'b1;
        sb.push_back('{who: 2'd1, rd: 1'b1, data: 8'h5A});
        sb.push_back('{who: 2'd2, rd: 1'b1, data: 8'h3C});
        tick();
        check("tie_grant_vid", 32'(grant), 32'd1);
        wait_ack(1, lat);
        vid_req = 1'b0;
        check("vid_latency", 32'(lat + 1), 32'd9);
        wait_ack(2, lat);
        cpu_req = 1'b0;
        check("cpu_after_vid", 32'(lat), 32'd11);
        repeat (2) tick();

        // Starvation: video and CPU held, loader pending
        vid_req = 1'b1; cpu_req = 1'b1;
        ldr_addr = 24'h000300; ldr_data = 8'h77; ldr_req = 1'b1;
        for (int k = 0; k < 4; k++) sb.push_back('{who: 2'd1, rd: 1'b1, data: 8'h5A});
        sb.push_back('{who: 2'd3, rd: 1'b0, data: 8'h00});
        sb.push_back('{who: 2'd1, rd: 1'b1, data: 8'h5A});
        for (int k = 0; k < 4; k++) wait_ack(1, lat);
        repeat (3) tick();
        check("starve_grant_ldr", 32'(grant), 32'd3);
        check("starve_ldr_we", 32'({ram_cs, ram_oe, ram_we}), 32'b101);
        check("starve_ldr_bus", 32'({ram_addr, ram_wdata}), 32'h00030077);
        wait_ack(3, lat);
        wait_ack(1, lat);
        vid_req = 1'b0; cpu_req = 1'b0; ldr_req = 1'b0;
        check("starve_sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) tick();

        // CPU write 0xA5 to 0x00FFFF, then read it back
        we_cycles = 0;
        cpu_addr = 24'h00FFFF; cpu_wdata = 8'hA5; cpu_we = 1'b1; cpu_req = 1'b1;
        sb.push_back('{who: 2'd2, rd: 1'b0, data: 8'h3C});
        wait_ack(2, lat);
        cpu_req = 1'b0;
        check("wr_we_cycles", 32'(we_cycles), 32'd8);
        cpu_we = 1'b0; cpu_req = 1'b1;
        sb.push_back('{who: 2'd2, rd: 1'b1, data: 8'hA5});
        wait_ack(2, lat);
        cpu_req = 1'b0;
        check("rd_no_we", 32'(we_cycles), 32'd8);
        check("vid_data_kept", 32'(vid_data), 32'h5A);
        repeat (2) tick();

        // Reset on the fourth access cycle
        cpu_addr = 24'h000123; cpu_we = 1'b0; cpu_req = 1'b1;
        repeat (4) tick();
        check("abort_in_access", 32'(ram_cs), 32'd1);
        rst = 1'b1; cpu_req = 1'b0;
        tick();
        check("abort_strobes", 32'({ram_cs, ram_oe, ram_we}), 32'd0);
        check("abort_grant", 32'(grant), 32'd0);
        check("abort_cpu_data", 32'(cpu_rdata), 32'd0);
        rst = 1'b0;
        lat = ack_total;
        repeat (12) tick();
        check("abort_no_ack", 32'(ack_total), 32'(lat));
        cpu_req = 1'b1;
        sb.push_back('{who: 2'd2, rd: 1'b1, data: 8'h5A});
        wait_ack(2, lat);
        cpu_req = 1'b0;
        check("post_abort_latency", 32'(lat), 32'd9);
        repeat (2) tick();

        // CPU request dropped right after being sampled
        cpu_addr = 24'h000200; cpu_we = 1'b0; cpu_req = 1'b1;
        sb.push_back('{who: 2'd2, rd: 1'b1, data: 8'h3C});
        tick();
        cpu_req = 1'b0;
        wait_ack(2, lat);
        check("drop_latency", 32'(lat + 1), 32'd9);
        check("drop_cs_len", 32'(last_cs_len), 32'd8);
        lat = ack_total;
        cs_cycles = 0;
        repeat (20) tick();
        check("drop_no_second_ack", 32'(ack_total), 32'(lat));
        check("drop_no_second_cs", 32'(cs_cycles), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single-port ssdram controller between three requesters: video fetch, Z80 CPU bus, and the ioctl/tape loader.
- Runs in the clk_sys domain, between lynx48 memory requests and ssdram's cs/oe/we/addr/data interface.
- ssdram has no ready handshake, so this block sequences each access with a fixed cycle budget.
- It also returns read data and a one-cycle ack to the requester it granted.

Parameters:
- ADDR_W, 24, address width for requesters and ssdram.
- DATA_W, 8, data width.
- ACCESS_CYCLES, 8, clock_i cycles ram_cs_o is held per access; read data is valid on the last of them; legal range 2..255.
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which a pending loader request is promoted to top priority; legal range 1..255.

Ports:
- clock_i  in  1  system clock (clk_sys).
- reset_i  in  1  synchronous, active-high reset.
- vid_req_i  in  1  video read request, level, held until ack.
- vid_addr_i  in  ADDR_W  video read address.
- vid_ack_o  out  1  one-cycle pulse: video access complete.
- vid_data_o  out  DATA_W  video read data, valid from ack, held until next video ack.
- cpu_req_i  in  1  CPU request, level, held until ack.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  ADDR_W  CPU address.
- cpu_data_i  in  DATA_W  CPU write data.
- cpu_ack_o  out  1  one-cycle pulse: CPU access complete.
- cpu_data_o  out  DATA_W  CPU read data, held until next CPU read ack.
- ldr_req_i  in  1  loader write request, level, held until ack.
- ldr_addr_i  in  ADDR_W  loader address.
- ldr_data_i  in  DATA_W  loader write data.
- ldr_ack_o  out  1  one-cycle pulse: loader write complete.
- ram_addr_o  out  ADDR_W  to ssdram addr_i.
- ram_data_o  out  DATA_W  to ssdram data_i.
- ram_data_i  in  DATA_W  from ssdram data_o.
- ram_cs_o  out  1  to ssdram cs_i.
- ram_oe_o  out  1  to ssdram oe_i.
- ram_we_o  out  1  to ssdram we_i.
- grant_o  out  2  current owner: 0 none, 1 video, 2 CPU, 3 loader.

Behaviour:
- Reset (synchronous, any state, including mid-access):
  - state IDLE; all outputs 0; data registers 0; starvation counter 0.
  - An aborted access produces no ack.
- State IDLE:
  - No request: stay IDLE.
  - Any request sampled high at edge t: latch winner's addr, data and we; set grant_o; go ACCESS.
  - Priority is video > CPU > loader.
  - Exception: if starve_cnt >= STARVE_LIMIT and ldr_req_i = 1, the loader wins.
- State ACCESS (cycles t+1 .. t+ACCESS_CYCLES):
  - ram_cs_o = 1.
  - Read: ram_oe_o = 1, ram_we_o = 0. Write: ram_we_o = 1, ram_oe_o = 0.
  - ram_addr_o and ram_data_o are stable for the whole window.
  - Loader accesses are always writes; video accesses are always reads.
  - A down-counter loads ACCESS_CYCLES-1 on entry; at 0 go DONE.
- State DONE (cycle t+ACCESS_CYCLES+1):
  - ram_cs_o, ram_oe_o and ram_we_o return to 0.
  - Owner's ack pulses for exactly one cycle.
  - On a read, the owner's data register is loaded from ram_data_i as sampled on the last ACCESS cycle.
  - Go GAP.
- State GAP (one cycle):
  - grant_o = 0, all strobes 0; go IDLE.
  - This guarantees ack-to-new-request turnaround and a strobe gap at ssdram.
- Timing:
  - Latency from request sampled to ack = ACCESS_CYCLES+1 cycles.
  - Back-to-back throughput is one access per ACCESS_CYCLES+3 cycles.
- Starvation counter:
  - Increments, saturating at 255, each IDLE arbitration in which ldr_req_i = 1 and the loader loses.
  - Clears when the loader is granted or ldr_req_i = 0 in IDLE.
- Request dropped before grant: ignored, no ack.
- Request dropped after grant: the access completes and ack still pulses; requesters must tolerate this.
- Request changes while in ACCESS: no effect; latched values are used.
- A requester holding req high after its ack is treated as a new request at the next IDLE.
- Only one ack is high in any cycle; acks are never asserted outside DONE.
- Non-owner data registers are unchanged by any access.

Test Plan:
- Reset, then CPU read at addr 0x000123 (ssdram model returns 0x5A):
  - ram_cs_o high for exactly 8 cycles.
  - cpu_ack_o pulses 9 cycles after req is sampled; cpu_data_o = 0x5A and is held.
- Video and CPU request in the same cycle:
  - Video granted first (grant_o = 1).
  - CPU granted in the IDLE after GAP; CPU ack 11 cycles after video ack.
- Video and CPU requests held continuously with loader pending:
  - Loader loses 4 arbitrations, then wins the 5th (grant_o = 3, ram_we_o = 1, ldr_data_i written).
  - Counter then clears.
- CPU write 0xA5 to 0x00FFFF, then CPU read of the same address:
  - Read returns 0xA5; ram_we_o high only during the write window; vid_data_o unchanged.
- Reset asserted on the 4th ACCESS cycle:
  - Next cycle: all strobes 0, grant_o = 0, no ack.
  - A fresh request afterwards completes normally.
- CPU req dropped one cycle after being sampled:
  - Access still runs 8 cycles and cpu_ack_o pulses once.
  - No second access is started.
